pj_dmem_sb_top: RTL

- Data-memory subsystem that sits directly downstream of the core's data-memory interface.
- Serves core loads combinationally and absorbs core stores into an in-order store buffer.
- The buffer drains into a single-ported word array whenever the port is not used by a load.
- Loads forward from the youngest matching buffered store, so the core sees a coherent memory despite the shared port.

---
 rtl/pj_dmem_sb_pkg.sv | 33 +++
 rtl/pj_dmem_sb_store_buffer.sv | 122 ++++++++++++
 rtl/pj_dmem_sb_top.sv | 70 +++++++
 3 files changed

// File: rtl/pj_dmem_sb_pkg.sv
// Shared constants and types for the data-memory store-buffer subsystem.
// Optional feature macro: PJ_DMEM_COALESCE_EN (store coalescing in the buffer).
package pj_dmem_sb_pkg;

    localparam int WORD_SIZE_P   = 16;
    localparam int PJ_DMEM_WORDS = 1024;
    localparam int PJ_SB_ELS     = 8;

    localparam int MEM_WORDS_P = PJ_DMEM_WORDS;
    localparam int SB_ELS_P    = PJ_SB_ELS;

    localparam int IDX_W    = $clog2(MEM_WORDS_P);
    localparam int SB_PTR_W = $clog2(SB_ELS_P);
    localparam int SB_CNT_W = SB_PTR_W + 1;

    typedef logic [WORD_SIZE_P-1:0] word_t;
    typedef logic [IDX_W-1:0]       idx_t;
    typedef logic [SB_PTR_W-1:0]    ptr_t;
    typedef logic [SB_CNT_W-1:0]    cnt_t;

    localparam cnt_t SB_FULL_CNT = cnt_t'(SB_ELS_P);

    typedef struct packed {
        idx_t  idx;
        word_t data;
    } pj_sb_entry_s;

    // Word address to array index; upper address bits alias onto the array.
    function automatic idx_t addr_to_idx(input word_t addr);
        return addr[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/pj_dmem_sb_store_buffer.sv
// In-order store buffer: circular FIFO, occupancy, youngest-match forwarding,
// sticky overflow. With PJ_DMEM_COALESCE_EN defined, a store that matches a
// buffered entry overwrites it in place instead of allocating.
module pj_dmem_sb_store_buffer
    import pj_dmem_sb_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         w_v_i,
    input  idx_t         w_idx_i,
    input  word_t        w_data_i,
    input  logic         r_v_i,
    input  idx_t         r_idx_i,
    output pj_sb_entry_s head_entry_o,
    output logic         drain_v_o,
    output logic         fwd_hit_o,
    output word_t        fwd_data_o,
    output cnt_t         count_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         overflow_o
);

    pj_sb_entry_s          entries_q [SB_ELS_P];
    logic [SB_ELS_P-1:0]   valid_q, valid_d;
    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;
    cnt_t                  count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic drain_v;
    logic full;
    logic enq;
    logic drop;
    logic coalesce;
    ptr_t co_ptr;

    // Forwarding: scan oldest to youngest so the last hit is the youngest match.
    always_comb begin
        // NOTE: every combinationally assigned variable gets a default first so no latch is inferred.
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < SB_ELS_P; i++) begin
            if (valid_q[head_q + ptr_t'(i)] &&
                entries_q[head_q + ptr_t'(i)].idx == r_idx_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = entries_q[head_q + ptr_t'(i)].data;
            end
        end
    end

    // Next-state: drain/enqueue/coalesce decisions and pointer/count updates.
    always_comb begin
        drain_v  = (count_q != '0) && !r_v_i;
        full     = (count_q == SB_FULL_CNT);
        coalesce = 1'b0;
        co_ptr   = '0;
`ifdef PJ_DMEM_COALESCE_EN
        begin
            logic co_hit;
            co_hit = 1'b0;
            for (int i = 0; i < SB_ELS_P; i++) begin
                if (valid_q[head_q + ptr_t'(i)] &&
                    entries_q[head_q + ptr_t'(i)].idx == w_idx_i) begin
                    co_hit = 1'b1;
                    co_ptr = head_q + ptr_t'(i);
                end
            end
            // A head entry leaving this edge cannot absorb the store.
            coalesce = w_v_i && co_hit && !(co_ptr == head_q && drain_v);
        end
`endif
        enq  = w_v_i && !coalesce && (!full || drain_v);
        drop = w_v_i && !coalesce && full && !drain_v;

        head_d     = head_q + ptr_t'(drain_v);
        tail_d     = tail_q + ptr_t'(enq);
        count_d    = count_q + cnt_t'(enq) - cnt_t'(drain_v);
        overflow_d = overflow_q | drop;

        valid_d = valid_q;
        if (drain_v) valid_d[head_q] = 1'b0;
        // When full and draining, tail equals head: the freed slot is refilled.
        if (enq)     valid_d[tail_q] = 1'b1;
    end

    // Control state: pointers, count, valid bits and sticky overflow.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry payload storage: allocate at tail, or overwrite a coalesced entry.
    // NOTE: payload is not reset; the valid bits alone decide whether an entry is meaningful.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            entries_q[tail_q] <= '{idx: w_idx_i, data: w_data_i};
        end else if (coalesce) begin
            entries_q[co_ptr].data <= w_data_i;
        end
    end

    assign head_entry_o = entries_q[head_q];
    assign drain_v_o    = drain_v;
    assign count_o      = count_q;
    assign full_o       = full;
    assign empty_o      = (count_q == '0);
    assign overflow_o   = overflow_q;

endmodule

// File: rtl/pj_dmem_sb_top.sv
// Data-memory subsystem: single-ported word array fed by an in-order store
// buffer. Loads own the port; the buffer drains on load-free cycles.
// Optional feature macro: PJ_DMEM_COALESCE_EN (handled in the store buffer).
module pj_dmem_sb_top
    import pj_dmem_sb_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   data_mem_w_v_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_w_addr_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_w_data_i,
    input  logic                   data_mem_r_v_i,
    input  logic [WORD_SIZE_P-1:0] data_mem_r_addr_i,
    output logic [WORD_SIZE_P-1:0] data_mem_r_data_o,
    output logic [SB_CNT_W-1:0]    sb_count_o,
    output logic                   sb_full_o,
    output logic                   sb_empty_o,
    output logic                   overflow_o
);

    word_t        mem_q [MEM_WORDS_P];
    pj_sb_entry_s head_entry;
    logic         drain_v;
    logic         fwd_hit;
    word_t        fwd_data;
    idx_t         r_idx;
    idx_t         w_idx;

    assign r_idx = addr_to_idx(data_mem_r_addr_i);
    assign w_idx = addr_to_idx(data_mem_w_addr_i);

    // Upper address bits alias onto the array and are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_mem_r_addr_i[WORD_SIZE_P-1:IDX_W],
                                data_mem_w_addr_i[WORD_SIZE_P-1:IDX_W]};

    pj_dmem_sb_store_buffer u_sb (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .w_v_i        (data_mem_w_v_i),
        .w_idx_i      (w_idx),
        .w_data_i     (data_mem_w_data_i),
        .r_v_i        (data_mem_r_v_i),
        .r_idx_i      (r_idx),
        .head_entry_o (head_entry),
        .drain_v_o    (drain_v),
        .fwd_hit_o    (fwd_hit),
        .fwd_data_o   (fwd_data),
        .count_o      (sb_count_o),
        .full_o       (sb_full_o),
        .empty_o      (sb_empty_o),
        .overflow_o   (overflow_o)
    );

    // Array write port: the only writer is the buffer drain.
    always_ff @(posedge clk_i) begin
        if (drain_v) begin
            mem_q[head_entry.idx] <= head_entry.data;
        end
    end

    // Load mux: youngest buffered store wins over the array; idle reads return 0.
    always_comb begin
        data_mem_r_data_o = '0;
        if (data_mem_r_v_i) begin
            data_mem_r_data_o = fwd_hit ? fwd_data : mem_q[r_idx];
        end
    end

endmodule
